pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Fetch-stage program-counter sequencer for the RV32I core; it replaces the
//  discrete pc adder / next-pc mux pair. Holds the PC register, advances by INC
//  on each accepted fetch, and selects among NUM_REDIR prioritised redirect
//  channels (branch, jump, trap, debug). Drives a valid/ready request to
//  instruction memory and counts accepted fetches.
// PARAMETERS
//  XLEN          32            PC / target width
//  NUM_REDIR     4             redirect channels; index 0 = highest priority
//  RESET_VECTOR  32'h0000_0000 PC value loaded on reset (XLEN bits)
//  INC           4             sequential increment, bytes
//  CNT_W         16            width of fetch counter
// PORTS
//  clk             in   1               rising-edge clock
//  rst_n           in   1               async active-low reset
//  stall_i         in   1               hazard stall; hold PC, drop request
//  halt_i          in   1               enter HALT (e.g. ebreak/wfi)
//  redir_valid_i   in   NUM_REDIR       per-channel redirect request
//  redir_target_i  in   NUM_REDIR*XLEN  ch k target = [k*XLEN +: XLEN]
//  pc_ready_i      in   1               imem accepts pc_o this cycle
//  pc_o            out  XLEN            current fetch address (registered)
//  pc_valid_o      out  1               fetch request valid (registered)
//  redir_taken_o   out  1               1-cycle pulse: redirect applied last edge
//  fetch_cnt_o     out  CNT_W           accepted-fetch count, wraps
//  misalign_o      out  1               see CONFIGURATION
// BEHAVIOUR
//  - One clock; reset is asynchronous, active-low (rst_n); all regs clear on its assertion.
//  - Reset values: pc_o=RESET_VECTOR, pc_valid_o=0, redir_taken_o=0,
//    fetch_cnt_o=0, misalign_o=0, state=BOOT.
//  - All outputs registered; redirect sampled at edge N -> pc_o=target after N.
//  - States: BOOT, RUN, HOLD, HALT. Per edge, priority high->low:
//    1 redirect: any redir_valid_i, in any state except BOOT -> pc_o<=target of lowest
//      set index, redir_taken_o<=1, state<=RUN, pc_valid_o<=1. Abandons any
//      pending unaccepted request; fetch_cnt_o not incremented that edge, even
//      if pc_ready_i was high.
//    2 halt_i -> HALT, pc_valid_o<=0, pc held. Only a redirect leaves HALT.
//    3 stall_i (RUN/HOLD) -> HOLD, pc_valid_o<=0, pc held.
//    4 RUN, pc_valid_o&pc_ready_i -> pc_o<=pc_o+INC (mod 2^XLEN, wraps),
//      fetch_cnt_o+=1 (mod 2^CNT_W).
//    5 RUN, pc_valid_o&!pc_ready_i -> hold; pc_o stable, pc_valid_o stays 1.
//    6 HOLD, !stall_i -> RUN, pc_valid_o<=1, same pc_o (no skip, no repeat).
//  - BOOT: first edge after rst_n release -> RUN, pc_valid_o<=1; redir, halt, stall
//    ignored on that edge.
//  - Handshake accepted only when pc_valid_o&pc_ready_i; pc_ready_i while
//    pc_valid_o=0 ignored.
//  - rst_n asserted mid-request: request dropped immediately (async), no count.
// CONFIGURATION
//  PC_MISALIGN_CHECK_EN defined: redirect whose target[1:0]!=0 is not applied;
//    state<=HALT, pc_valid_o<=0, pc_o<=offending target, misalign_o<=1 (sticky
//    until reset or next aligned redirect). redir_taken_o stays 0.
//  Not defined: targets used as-is, misalign_o tied 0, no extra logic.
// TESTING
//  T1 reset release -> BOOT 1 cycle, then pc_o=0x0, pc_valid_o=1; ready held 1
//     for 3 cycles -> pc 0x4,0x8,0xC, fetch_cnt_o=3.
//  T2 pc_ready_i=0 for 5 cycles at pc=0x10 -> pc_o stays 0x10, valid 1, cnt same.
//  T3 redir_valid_i=4'b0110, ch1=0x100, ch2=0x200, ready=1 -> pc_o=0x100,
//     redir_taken_o pulse 1 cycle, cnt unchanged that edge.
//  T4 stall_i 3 cycles at pc=0x20 -> valid 0, pc 0x20; release -> valid 1 at 0x20;
//     halt_i -> HALT; ch3 redirect 0x300 -> RUN at 0x300.
//  T5 pc=0xFFFF_FFFC accepted -> pc_o=0x0000_0000; cnt 0xFFFF -> 0x0000.
//  T6 (PC_MISALIGN_CHECK_EN) redirect ch0=0x102 -> misalign_o=1, HALT,
//     pc_o=0x102, valid 0; redirect ch0=0x104 -> misalign_o=0, RUN at 0x104.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: PC register, prioritised redirects, imem valid/ready request, fetch counter.
// Latency: all outputs registered; a redirect sampled at edge N drives pc_o from edge N.
// Backpressure: pc_ready_i low holds pc_o with pc_valid_o high; optional PC_MISALIGN_CHECK_EN halts on misaligned targets.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     NUM_REDIR    = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall_i,
  input  logic                      halt_i,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target_i,
  input  logic                      pc_ready_i,
  output logic [XLEN-1:0]           pc_o,
  output logic                      pc_valid_o,
  output logic                      redir_taken_o,
  output logic [CNT_W-1:0]          fetch_cnt_o,
  output logic                      misalign_o
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              vld_q, vld_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              redir_any;
  logic [XLEN-1:0]   redir_tgt;
  logic              redir_bad;

  // Lowest set channel index wins: scan from the top so lower indices overwrite.
  always_comb begin
    redir_any = |redir_valid_i;
    redir_tgt = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        redir_tgt = redir_target_i[k*XLEN +: XLEN];
      end
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign redir_bad  = (redir_tgt[1:0] != 2'b00);
  assign misalign_o = mis_q;
`else
  assign redir_bad  = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    taken_d = 1'b0;
    cnt_d   = cnt_q;
`ifdef PC_MISALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
      vld_d   = 1'b1;
    end else if (redir_any && redir_bad) begin
      state_d = ST_HALT;
      vld_d   = 1'b0;
      pc_d    = redir_tgt;
`ifdef PC_MISALIGN_CHECK_EN
      mis_d   = 1'b1;
`endif
    end else if (redir_any) begin
      // Redirect abandons any outstanding request, so no count this edge.
      state_d = ST_RUN;
      vld_d   = 1'b1;
      pc_d    = redir_tgt;
      taken_d = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
      mis_d   = 1'b0;
`endif
    end else if (halt_i) begin
      state_d = ST_HALT;
      vld_d   = 1'b0;
    end else if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (stall_i) begin
      state_d = ST_HOLD;
      vld_d   = 1'b0;
    end else if (state_q == ST_HOLD) begin
      state_d = ST_RUN;
      vld_d   = 1'b1;
    end else if (vld_q && pc_ready_i) begin
      pc_d  = pc_q + XLEN'(INC);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      vld_q   <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
`endif

  assign pc_o          = pc_q;
  assign pc_valid_o    = vld_q;
  assign redir_taken_o = taken_q;
  assign fetch_cnt_o   = cnt_q;

endmodule
